ob_table_cnt_cpa: RTL and testbench



---
 rtl/ob_pkg.sv | 21 ++
 rtl/ob_table_cnt_cpa_if.sv | 30 +++
 rtl/ob_table_cnt_cpa_slice.sv | 18 +
 rtl/ob_table_cnt_cpa.sv | 156 +++++++++++++++
 tb/tb_ob_table_cnt_cpa.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/ob_pkg.sv
// -----------------------------------------------------------------------------
// ob_pkg
//   Shared types and helpers for the table-count datapath.
//   - cpa_state_t : control states of the chunked carry-propagate adder
//   - ceil_div    : integer ceiling division, used to size the chunk count
// -----------------------------------------------------------------------------
package ob_pkg;

  // Explicit 2-bit encoding keeps the state register legacy-compatible with
  // code that compares against plain logic [1:0] constants.
  typedef enum logic [1:0] {
    CPA_IDLE = 2'd0,
    CPA_ADD  = 2'd1,
    CPA_DONE = 2'd2
  } cpa_state_t;

  function automatic int ceil_div(int a, int b);
    return (a + b - 1) / b;
  endfunction

endpackage

// File: rtl/ob_table_cnt_cpa_if.sv
// -----------------------------------------------------------------------------
// ob_table_cnt_cpa_if
//   Operand/result handshake bundle for ob_table_cnt_cpa.
//   Input side : in_vld, in_s, in_c (producer -> adder), in_rdy (adder -> producer)
//   Output side: out_vld, out_sum, out_ovf (adder -> consumer), out_rdy (consumer -> adder)
//   Modports   : slave  = the adder
//                master = the environment driving operands and taking results
// -----------------------------------------------------------------------------
interface ob_table_cnt_cpa_if #(
  parameter int W = 32
);
  logic         in_vld;
  logic [W-1:0] in_s;
  logic [W-1:0] in_c;
  logic         in_rdy;
  logic         out_vld;
  logic [W-1:0] out_sum;
  logic         out_ovf;
  logic         out_rdy;

  modport slave (
    input  in_vld, in_s, in_c, out_rdy,
    output in_rdy, out_vld, out_sum, out_ovf
  );

  modport master (
    output in_vld, in_s, in_c, out_rdy,
    input  in_rdy, out_vld, out_sum, out_ovf
  );
endinterface

// File: rtl/ob_table_cnt_cpa_slice.sv
// -----------------------------------------------------------------------------
// ob_table_cnt_cpa_slice
//   One CHUNK-bit slice of the carry-propagate adder: {cout, sum} = a + b + cin.
//   Ports: a, b (CHUNK) operands; cin carry in; sum (CHUNK); cout carry out.
// -----------------------------------------------------------------------------
module ob_table_cnt_cpa_slice #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};

endmodule

// File: rtl/ob_table_cnt_cpa.sv
// -----------------------------------------------------------------------------
// ob_table_cnt_cpa
//   Resolves the CSA tree's redundant sum/carry pair into a binary count using
//   a multi-cycle carry-propagate adder that settles CHUNK bits per cycle, so
//   no full-width carry chain sits between two registers.
//   Ports:
//     clk  clock
//     rst  synchronous reset, active-high
//     bus  ob_table_cnt_cpa_if.slave
//          in_vld/in_s/in_c/in_rdy   operand handshake
//          out_vld/out_sum/out_ovf/out_rdy result handshake
//   Latency: operand accepted at edge T -> out_vld high from cycle T+NCHUNK+1.
// -----------------------------------------------------------------------------
module ob_table_cnt_cpa
  import ob_pkg::*;
#(
  parameter int W     = 32,
  parameter int CHUNK = 8
) (
  input  logic                clk,
  input  logic                rst,
  ob_table_cnt_cpa_if.slave   bus
);

  localparam int NCHUNK = ceil_div(W, CHUNK);
  localparam int PAD_W  = NCHUNK * CHUNK;
  localparam int IDX_W  = $clog2(NCHUNK + 1);
  // Width of the top chunk that actually holds result bits (1..CHUNK).
  localparam int LAST_W = W - (NCHUNK - 1) * CHUNK;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

  cpa_state_t       state;
  logic [IDX_W-1:0] idx;
  logic             cy;
  logic [W-1:0]     op_s;
  logic [W-1:0]     op_c;
  logic [W-1:0]     out_sum;
  logic             out_ovf;

  logic             accept;
  logic [PAD_W-1:0] s_pad;
  logic [PAD_W-1:0] c_pad;
  logic [CHUNK-1:0] slice_a;
  logic [CHUNK-1:0] slice_b;
  logic [CHUNK-1:0] slice_sum;
  logic             slice_cout;
  logic             last_carry;

  // Handshake outputs decode registered state only; in_rdy is allowed to
  // follow out_rdy combinationally so a result can be retired and the next
  // operand pair loaded on the same edge.
  assign bus.in_rdy  = (state == CPA_IDLE) | ((state == CPA_DONE) & bus.out_rdy);
  assign bus.out_vld = (state == CPA_DONE);
  assign bus.out_sum = out_sum;
  assign bus.out_ovf = out_ovf;
  assign accept      = bus.in_vld & bus.in_rdy;

  // Operands zero-padded to a whole number of chunks; the padding is what
  // masks off the unused upper bits of a partial top chunk.
  always_comb begin
    // NOTE: every always_comb output gets a default before any branch so no
    // path leaves it unassigned and a latch is never inferred.
    s_pad          = '0;
    c_pad          = '0;
    s_pad[W-1:0]   = op_s;
    c_pad[W-1:0]   = op_c;
    slice_a        = '0;
    slice_b        = '0;
    for (int k = 0; k < NCHUNK; k++) begin
      if (idx == IDX_W'(k)) begin
        slice_a = s_pad[k*CHUNK +: CHUNK];
        slice_b = c_pad[k*CHUNK +: CHUNK];
      end
    end
  end

  ob_table_cnt_cpa_slice #(
    .CHUNK (CHUNK)
  ) u_slice (
    .a    (slice_a),
    .b    (slice_b),
    .cin  (cy),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

  // Overflow is the carry out of bit W-1. With a partial top chunk the padded
  // operands are zero above W-1, so that carry lands in the first padding bit
  // of the slice sum rather than in the slice carry-out.
  generate
    if (LAST_W == CHUNK) begin : g_full_top
      assign last_carry = slice_cout;
    end else begin : g_part_top
      assign last_carry = slice_sum[LAST_W];
    end
  endgenerate

  // NOTE: operand registers are deliberately left out of reset: they are only
  // read in ADD, and ADD is always entered through a load on the accept edge.
  always_ff @(posedge clk) begin
    if (accept) begin
      op_s <= bus.in_s;
      op_c <= bus.in_c;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= CPA_IDLE;
      idx     <= '0;
      cy      <= 1'b0;
      out_sum <= '0;
      out_ovf <= 1'b0;
    end else begin
      case (state)
        CPA_IDLE: begin
          if (accept) begin
            idx   <= '0;
            cy    <= 1'b0;
            state <= CPA_ADD;
          end
        end

        CPA_ADD: begin
          for (int i = 0; i < W; i++) begin
            if (idx == IDX_W'(i / CHUNK)) out_sum[i] <= slice_sum[i % CHUNK];
          end
          if (idx == LAST_IDX) begin
            out_ovf <= last_carry;
            state   <= CPA_DONE;
          end else begin
            cy  <= slice_cout;
            idx <= idx + 1'b1;
          end
        end

        CPA_DONE: begin
          if (bus.out_rdy) begin
            if (bus.in_vld) begin
              idx   <= '0;
              cy    <= 1'b0;
              state <= CPA_ADD;
            end else begin
              state <= CPA_IDLE;
            end
          end
        end

        default: state <= CPA_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ob_table_cnt_cpa.sv
// -----------------------------------------------------------------------------
// tb_ob_table_cnt_cpa
//   Self-checking bench for ob_table_cnt_cpa. Three instances share clk/rst:
//     id 0: W=32, CHUNK=8 (NCHUNK=4)
//     id 1: W=20, CHUNK=8 (NCHUNK=3, partial top chunk)
//     id 2: W=8,  CHUNK=8 (NCHUNK=1)
//   Expected results come from plain (W+1)-bit addition of the operands.
// -----------------------------------------------------------------------------
module tb_ob_table_cnt_cpa;

  logic clk;
  logic rst;

  int n_cmp = 0;
  int n_bad = 0;

  ob_table_cnt_cpa_if #(.W(32)) b32 ();
  ob_table_cnt_cpa_if #(.W(20)) b20 ();
  ob_table_cnt_cpa_if #(.W(8))  b8  ();

  ob_table_cnt_cpa #(.W(32), .CHUNK(8)) dut32 (.clk(clk), .rst(rst), .bus(b32));
  ob_table_cnt_cpa #(.W(20), .CHUNK(8)) dut20 (.clk(clk), .rst(rst), .bus(b20));
  ob_table_cnt_cpa #(.W(8),  .CHUNK(8)) dut8  (.clk(clk), .rst(rst), .bus(b8));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    int          id;
    logic [31:0] s;
    logic [31:0] c;
    logic [31:0] sum;
    logic        ovf;
    int          lat;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int id, input logic v, input logic [31:0] s,
                       input logic [31:0] c, input logic ordy);
    case (id)
      0: begin b32.in_vld = v; b32.in_s = s;       b32.in_c = c;       b32.out_rdy = ordy; end
      1: begin b20.in_vld = v; b20.in_s = s[19:0]; b20.in_c = c[19:0]; b20.out_rdy = ordy; end
      default: begin b8.in_vld = v; b8.in_s = s[7:0]; b8.in_c = c[7:0]; b8.out_rdy = ordy; end
    endcase
  endtask

  function automatic logic get_vld(input int id);
    case (id)
      0:       return b32.out_vld;
      1:       return b20.out_vld;
      default: return b8.out_vld;
    endcase
  endfunction

  function automatic logic get_rdy(input int id);
    case (id)
      0:       return b32.in_rdy;
      1:       return b20.in_rdy;
      default: return b8.in_rdy;
    endcase
  endfunction

  function automatic logic [31:0] get_sum(input int id);
    case (id)
      0:       return b32.out_sum;
      1:       return {12'b0, b20.out_sum};
      default: return {24'b0, b8.out_sum};
    endcase
  endfunction

  function automatic logic get_ovf(input int id);
    case (id)
      0:       return b32.out_ovf;
      1:       return b20.out_ovf;
      default: return b8.out_ovf;
    endcase
  endfunction

  // Steps until out_vld is seen; lat counts the accept edge as 1. Bounded.
  task automatic wait_vld(input int id, output int lat);
    lat = 1;
    while (!get_vld(id) && lat < 20) begin
      step();
      lat++;
    end
  endtask

  // One isolated operation: accept, scramble inputs, wait, check, retire.
  task automatic run_op(input int id, input logic [31:0] s, input logic [31:0] c,
                        input logic [31:0] exp_sum, input logic exp_ovf,
                        input int exp_lat, input string name);
    int lat;
    drive(id, 1'b1, s, c, 1'b1);
    #1;
    check({name, " in_rdy"}, get_rdy(id), 1);
    step();
    drive(id, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    wait_vld(id, lat);
    check({name, " latency"}, lat, exp_lat);
    check({name, " sum"}, get_sum(id), exp_sum);
    check({name, " ovf"}, get_ovf(id), exp_ovf);
    step();
    check({name, " retired"}, get_vld(id), 0);
  endtask

  vec_t        vecs[11];
  logic [32:0] model_q[$];

  initial begin
    int          lat;
    logic        v;
    logic        ordy;
    logic [31:0] rs;
    logic [31:0] rc;
    logic [32:0] exp33;

    vecs[0]  = '{0, 32'h0000_00FF, 32'h0000_0002, 32'h0000_0101, 1'b0, 5};
    vecs[1]  = '{0, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 1'b1, 5};
    vecs[2]  = '{0, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b0, 5};
    vecs[3]  = '{0, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1'b1, 5};
    vecs[4]  = '{0, 32'h00FF_FF00, 32'h0000_0100, 32'h0100_0000, 1'b0, 5};
    vecs[5]  = '{0, 32'h1234_5678, 32'h1111_1110, 32'h2345_6788, 1'b0, 5};
    vecs[6]  = '{1, 32'h000F_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 4};
    vecs[7]  = '{1, 32'h0000_F000, 32'h0000_1000, 32'h0001_0000, 1'b0, 4};
    vecs[8]  = '{1, 32'h0008_0000, 32'h0008_0000, 32'h0000_0000, 1'b1, 4};
    vecs[9]  = '{2, 32'h0000_00FF, 32'h0000_0002, 32'h0000_0001, 1'b1, 2};
    vecs[10] = '{2, 32'h0000_0012, 32'h0000_0034, 32'h0000_0046, 1'b0, 2};

    rst = 1'b1;
    for (int id = 0; id < 3; id++) drive(id, 1'b0, 32'h0, 32'h0, 1'b1);
    step();
    step();
    rst = 1'b0;

    // Reset state
    for (int id = 0; id < 3; id++) begin
      check($sformatf("reset out_vld id%0d", id), get_vld(id), 0);
      check($sformatf("reset in_rdy id%0d", id), get_rdy(id), 1);
      check($sformatf("reset out_sum id%0d", id), get_sum(id), 0);
      check($sformatf("reset out_ovf id%0d", id), get_ovf(id), 0);
    end

    // Table vectors
    for (int i = 0; i < 11; i++)
      run_op(vecs[i].id, vecs[i].s, vecs[i].c, vecs[i].sum, vecs[i].ovf, vecs[i].lat,
             $sformatf("vec%0d", i));

    // Backpressure: result held for 3 stalled cycles, new operands refused
    drive(0, 1'b1, 32'h5, 32'h6, 1'b0);
    step();
    drive(0, 1'b0, 32'h0, 32'h0, 1'b0);
    wait_vld(0, lat);
    check("bp latency", lat, 5);
    drive(0, 1'b1, 32'h777, 32'h2, 1'b0);
    for (int k = 0; k < 3; k++) begin
      #1;
      check($sformatf("bp out_vld c%0d", k), b32.out_vld, 1);
      check($sformatf("bp sum c%0d", k), b32.out_sum, 32'hB);
      check($sformatf("bp in_rdy c%0d", k), b32.in_rdy, 0);
      step();
    end
    drive(0, 1'b0, 32'h0, 32'h0, 1'b1);
    #1;
    check("bp in_rdy follows out_rdy", b32.in_rdy, 1);
    step();
    check("bp retired", b32.out_vld, 0);

    // Back-to-back: second pair accepted on the first result's handshake
    drive(0, 1'b1, 32'h10, 32'h20, 1'b1);
    step();
    drive(0, 1'b1, 32'hFFFF_0000, 32'h0001_0000, 1'b1);
    wait_vld(0, lat);
    check("b2b first latency", lat, 5);
    check("b2b first sum", b32.out_sum, 32'h30);
    check("b2b first ovf", b32.out_ovf, 0);
    check("b2b in_rdy in done", b32.in_rdy, 1);
    step();
    drive(0, 1'b0, 32'h0, 32'h0, 1'b1);
    wait_vld(0, lat);
    check("b2b spacing", lat, 5);
    check("b2b second sum", b32.out_sum, 32'h0);
    check("b2b second ovf", b32.out_ovf, 1);
    step();
    check("b2b retired", b32.out_vld, 0);

    // Reset while idx==2 in ADD
    drive(0, 1'b1, 32'h1357_9BDF, 32'h2468_ACE0, 1'b1);
    step();
    drive(0, 1'b0, 32'h0, 32'h0, 1'b1);
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst out_vld", b32.out_vld, 0);
    check("midrst in_rdy", b32.in_rdy, 1);
    step();
    check("midrst stays idle", b32.out_vld, 0);
    run_op(0, 32'hDEAD_BEEF, 32'h0101_0100, 32'hDFAE_BFEF, 1'b0, 5, "after_rst");

    // Random operands and stalls against the arithmetic model
    for (int cyc = 0; cyc < 1500; cyc++) begin
      v    = ($urandom_range(9) < 7);
      ordy = ($urandom_range(9) < 6);
      rs   = $urandom;
      rc   = $urandom & 32'hFFFF_FFFE;
      drive(0, v, rs, rc, ordy);
      #1;
      if (b32.out_vld && b32.out_rdy) begin
        if (model_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL rand unexpected result: got 0x%0h, expected none", {b32.out_ovf, b32.out_sum});
        end else begin
          exp33 = model_q.pop_front();
          check("rand result", {b32.out_ovf, b32.out_sum}, exp33);
        end
      end
      if (b32.in_vld && b32.in_rdy) model_q.push_back({1'b0, rs} + {1'b0, rc});
      step();
    end
    drive(0, 1'b0, 32'h0, 32'h0, 1'b1);
    for (int k = 0; k < 20 && model_q.size() != 0; k++) begin
      #1;
      if (b32.out_vld) begin
        exp33 = model_q.pop_front();
        check("rand drain result", {b32.out_ovf, b32.out_sum}, exp33);
      end
      step();
    end
    check("rand drained", model_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
